coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front-end stage of the beverage vending machine. It takes the three raw, asynchronous, bouncy coin-sensor lines (1, 2 and 5 cent) and produces clean single-cycle `one` / `two` / `five` pulses for the vending FSM, which sits directly downstream. It also rejects coins that arrive simultaneously, during post-coin lockout, or while the machine is inhibited, and flags each rejection with a `reject` pulse that drives the coin-return flap.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized line must differ from its debounced level before that level flips. Legal range 1..15.
- `LOCKOUT_CYCLES`, default 8: cycles after an accepted coin during which any new coin event is rejected. Legal range 1..255.

Ports:
- `clk`  in  1: single system clock, all logic on posedge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `coin1_raw`  in  1: raw 1-cent sensor, asynchronous, active-high while the coin passes.
- `coin2_raw`  in  1: raw 2-cent sensor, same behaviour.
- `coin5_raw`  in  1: raw 5-cent sensor, same behaviour.
- `inhibit`  in  1: synchronous; when high, coin events are rejected.
- `one`  out  1: one-cycle pulse, accepted 1-cent coin.
- `two`  out  1: one-cycle pulse, accepted 2-cent coin.
- `five`  out  1: one-cycle pulse, accepted 5-cent coin.
- `reject`  out  1: one-cycle pulse, coin event rejected.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** each raw line passes through a 2-flop synchronizer; the second flop is `sN`.
- **Debounce (per line):**
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sN` ≠ debounced level, the counter increments. If equal, the counter clears.
  - When the counter is at `DEBOUNCE_CYCLES-1` and a mismatch persists, the debounced level takes `sN` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sN` never changes the debounced level.
- **Event:** a rising edge of a debounced level, detected against its previous-cycle copy. Falling edges generate nothing.
- **State machine, IDLE / LOCKOUT / RELEASE:**
  - IDLE, exactly one event, `inhibit` low: the matching output pulses, the lockout counter loads 0, next state is LOCKOUT.
  - IDLE, event with `inhibit` high: `reject` pulses, state stays IDLE.
  - IDLE, two or three events in the same cycle: `reject` pulses, state stays IDLE. No coin pulse, regardless of `inhibit`.
  - LOCKOUT: the counter increments each cycle. Any event pulses `reject`. When the counter is at `LOCKOUT_CYCLES-1`, next state is RELEASE.
  - RELEASE: any event pulses `reject`. When all three debounced levels are low, next state is IDLE. An event in that same transition cycle is still rejected.
- **Output rules:**
  - At most one of `one`/`two`/`five`/`reject` is high in any cycle.
  - `reject` is a single pulse per event cycle, even when several causes apply.
  - All four pulse outputs are registered.
- **Reset:**
  - All outputs 0, synchronizers, debounced levels and counters 0, state IDLE.
  - Reset mid-operation drops any in-flight event with no pulse.
  - A raw line already high when reset releases is treated as a new insertion.

## Timing
- Edge 0 is the first posedge at which a raw line is sampled high, with the line held stable afterwards.
- Sync output is high after edge 1, the debounced level flips at edge `DEBOUNCE_CYCLES+1`, and the output pulse is high from edge `DEBOUNCE_CYCLES+2` to edge `DEBOUNCE_CYCLES+3`. With defaults, the pulse is high between edges 6 and 7.
- Release has the same latency: the debounced level falls at edge `DEBOUNCE_CYCLES+1` after the raw fall is first sampled.
- `busy` rises on the same edge as the coin pulse and is registered from the state.
- The minimum spacing between two accepted coins is `LOCKOUT_CYCLES+1` cycles of state plus the release wait.
- `inhibit` is sampled in the cycle the event is detected, i.e. one cycle before the output edge.

## Test plan
- **Clean coin:** reset, then `coin2_raw` high for 10 cycles. Required: `two` high exactly one cycle at edge 6→7, `busy` high from edge 6, no `reject`, back to IDLE after the line is low and debounced.
- **Glitches:** `coin5_raw` pulses of 1, 2 and 3 cycles, 10 cycles apart. Required: no output pulse at all. A 4-cycle pulse yields one `five` pulse.
- **Simultaneous coins:** `coin1_raw` and `coin5_raw` rise on the same edge and are held 6 cycles. Required: one `reject` pulse at edge 6→7, no coin pulse, state remains IDLE.
- **Lockout:** a 1-cent coin is accepted, then a 2-cent line rises 1 cycle after the first coin's debounced rise. Required: `one` once, then `reject` once, `busy` stays high until both lines are debounced low.
- **Inhibit:** `inhibit` high, `coin1_raw` inserted. Required: `reject` at edge 6→7, no `one`, `busy` low. Repeat with `inhibit` low: `one`.
- **Reset mid-flight:** assert `reset` 3 cycles after `coin5_raw` rises, release while the line is still high. Required: all outputs 0 during reset, then one `five` pulse `DEBOUNCE_CYCLES+2` edges after release.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: sync, debounce and vet raw coin sensor lines; emit clean
// one-cycle one/two/five/reject pulses for the vending FSM; busy != IDLE.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic coin1_raw,
    input  logic coin2_raw,
    input  logic coin5_raw,
    input  logic inhibit,
    output logic one,
    output logic two,
    output logic five,
    output logic reject,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCKOUT,
        RELEASE
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    ev;
    logic          multi;

    state_t        state;
    state_t        state_n;
    logic [LW-1:0] lk_cnt;
    logic [LW-1:0] lk_n;
    logic          one_n;
    logic          two_n;
    logic          five_n;
    logic          rej_n;

    assign raw = {coin5_raw, coin2_raw, coin1_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign ev    = deb & ~deb_q;
    assign multi = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);

    always_comb begin
        state_n = state;
        lk_n    = lk_cnt;
        one_n   = 1'b0;
        two_n   = 1'b0;
        five_n  = 1'b0;
        rej_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ev != 3'b000) begin
                    if (multi || inhibit) begin
                        rej_n = 1'b1;
                    end else begin
                        one_n   = ev[0];
                        two_n   = ev[1];
                        five_n  = ev[2];
                        lk_n    = '0;
                        state_n = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                rej_n = |ev;
                lk_n  = lk_cnt + LW'(1);
                if (lk_cnt == LK_LAST) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                rej_n = |ev;
                // Wait for every line to clear so a held coin is not re-seen.
                if (deb == 3'b000) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            lk_cnt <= '0;
            one    <= 1'b0;
            two    <= 1'b0;
            five   <= 1'b0;
            reject <= 1'b0;
        end else begin
            state  <= state_n;
            lk_cnt <= lk_n;
            one    <= one_n;
            two    <= two_n;
            five   <= five_n;
            reject <= rej_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and random stimulus for coin_acceptor, checked
// every cycle against a history-based behavioural model.
module tb_coin_acceptor;

    localparam int D = 4;
    localparam int L = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic coin1_raw = 1'b0;
    logic coin2_raw = 1'b0;
    logic coin5_raw = 1'b0;
    logic inhibit = 1'b0;
    logic one;
    logic two;
    logic five;
    logic reject;
    logic busy;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .coin1_raw(coin1_raw),
        .coin2_raw(coin2_raw),
        .coin5_raw(coin5_raw),
        .inhibit  (inhibit),
        .one      (one),
        .two      (two),
        .five     (five),
        .reject   (reject),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)",
                      name, act, exp, cyc);
    endtask

    // Model: raw samples delayed two edges, then a level flips once the
    // last D samples all disagree with it; events are level rises.
    logic [2:0]  m_p0, m_p1, m_deb, m_deb_q, m_raw, m_ev;
    logic [15:0] m_hist [3];
    logic        m_idle;
    int          m_acc;
    logic        e_one, e_two, e_five, e_rej, e_busy;
    logic [15:0] mask;

    always @(posedge clk) begin
        cyc++;
        m_raw = {coin5_raw, coin2_raw, coin1_raw};
        mask  = (16'(1) << D) - 16'(1);
        e_one = 0; e_two = 0; e_five = 0; e_rej = 0;
        if (reset) begin
            m_p0 = 0; m_p1 = 0; m_deb = 0; m_deb_q = 0;
            for (int i = 0; i < 3; i++) m_hist[i] = 0;
            m_idle = 1; m_acc = 0;
        end else begin
            m_ev = m_deb & ~m_deb_q;
            if (m_idle) begin
                if ($countones(m_ev) == 1 && !inhibit) begin
                    e_one = m_ev[0]; e_two = m_ev[1]; e_five = m_ev[2];
                    m_idle = 0;
                    m_acc  = cyc;
                end else if (m_ev != 0) begin
                    e_rej = 1;
                end
            end else begin
                if (m_ev != 0) e_rej = 1;
                if (cyc >= m_acc + L + 1 && m_deb == 0) m_idle = 1;
            end
            m_deb_q = m_deb;
            for (int i = 0; i < 3; i++) begin
                m_hist[i] = {m_hist[i][14:0], m_p1[i]};
                if (m_deb[i] ? ((m_hist[i] & mask) == 0)
                             : ((m_hist[i] & mask) == mask))
                    m_deb[i] = ~m_deb[i];
            end
            m_p1 = m_p0;
            m_p0 = m_raw;
        end
        e_busy = !m_idle;
    end

    int n_one = 0, n_two = 0, n_five = 0, n_rej = 0, n_brise = 0;
    int last_one = -1, last_two = -1, last_five = -1, last_rej = -1;
    int busy_rise = -1, busy_fall = -1;
    logic busy_d = 1'b0;

    always @(posedge clk) begin
        #1;
        chk("outputs_one_two_five_rej_busy",
            int'({one, two, five, reject, busy}),
            int'({e_one, e_two, e_five, e_rej, e_busy}));
        if (one)    begin n_one++;  last_one  = cyc; end
        if (two)    begin n_two++;  last_two  = cyc; end
        if (five)   begin n_five++; last_five = cyc; end
        if (reject) begin n_rej++;  last_rej  = cyc; end
        if (!busy_d && busy) begin busy_rise = cyc; n_brise++; end
        if (busy_d && !busy) busy_fall = cyc;
        busy_d = busy;
    end

    task automatic idle_wait(input string name);
        int k = 0;
        while ((busy || coin1_raw || coin2_raw || coin5_raw) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (D + 8) @(negedge clk);
        chk(name, int'(busy), 0);
    endtask

    int e0, r0, c0, c1, c2, b0, acc0;
    logic [2:0] lv;
    int hold [3];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({one, two, five, reject, busy}), 0);
        reset = 0;
        repeat (4) @(negedge clk);

        // clean 2-cent coin
        c0 = n_two; r0 = n_rej;
        coin2_raw = 1; e0 = cyc + 1;
        repeat (10) @(negedge clk);
        coin2_raw = 0;
        repeat (14) @(negedge clk);
        chk("clean_two_count", n_two - c0, 1);
        chk("clean_two_edge", last_two - e0, 6);
        chk("clean_busy_rise", busy_rise - e0, 6);
        chk("clean_busy_fall", busy_fall - e0, 16);
        chk("clean_no_reject", n_rej - r0, 0);
        idle_wait("clean_idle");

        // glitches of 1..3 cycles then a 4-cycle pulse
        c0 = n_five; r0 = n_rej;
        for (int len = 1; len <= 3; len++) begin
            coin5_raw = 1;
            repeat (len) @(negedge clk);
            coin5_raw = 0;
            repeat (10) @(negedge clk);
        end
        chk("glitch_no_five", n_five - c0, 0);
        chk("glitch_no_reject", n_rej - r0, 0);
        coin5_raw = 1; e0 = cyc + 1;
        repeat (4) @(negedge clk);
        coin5_raw = 0;
        repeat (10) @(negedge clk);
        chk("pulse4_five_count", n_five - c0, 1);
        chk("pulse4_five_edge", last_five - e0, 6);
        idle_wait("pulse4_idle");

        // simultaneous 1 + 5
        c0 = n_one; c1 = n_five; r0 = n_rej; b0 = n_brise;
        coin1_raw = 1; coin5_raw = 1; e0 = cyc + 1;
        repeat (6) @(negedge clk);
        coin1_raw = 0; coin5_raw = 0;
        repeat (12) @(negedge clk);
        chk("simul_reject_count", n_rej - r0, 1);
        chk("simul_reject_edge", last_rej - e0, 6);
        chk("simul_no_coin", (n_one - c0) + (n_five - c1), 0);
        chk("simul_no_busy", n_brise - b0, 0);
        idle_wait("simul_idle");

        // lockout: 2-cent line rises one cycle after the 1-cent debounced rise
        c0 = n_one; c1 = n_two; r0 = n_rej; b0 = n_brise;
        coin1_raw = 1; e0 = cyc + 1;
        repeat (6) @(negedge clk);
        coin2_raw = 1;
        repeat (6) @(negedge clk);
        coin1_raw = 0;
        repeat (4) @(negedge clk);
        coin2_raw = 0;
        repeat (10) @(negedge clk);
        chk("lock_one_count", n_one - c0, 1);
        chk("lock_one_edge", last_one - e0, 6);
        chk("lock_reject_count", n_rej - r0, 1);
        chk("lock_reject_edge", last_rej - e0, 12);
        chk("lock_no_two", n_two - c1, 0);
        chk("lock_busy_once", n_brise - b0, 1);
        chk("lock_busy_fall", busy_fall - e0, 22);
        idle_wait("lock_idle");

        // inhibit high then low
        c0 = n_one; r0 = n_rej; b0 = n_brise;
        inhibit = 1;
        coin1_raw = 1; e0 = cyc + 1;
        repeat (8) @(negedge clk);
        coin1_raw = 0;
        repeat (14) @(negedge clk);
        chk("inh_reject_edge", last_rej - e0, 6);
        chk("inh_reject_count", n_rej - r0, 1);
        chk("inh_no_one", n_one - c0, 0);
        chk("inh_no_busy", n_brise - b0, 0);
        inhibit = 0;
        coin1_raw = 1; e0 = cyc + 1;
        repeat (8) @(negedge clk);
        coin1_raw = 0;
        repeat (4) @(negedge clk);
        chk("uninh_one_count", n_one - c0, 1);
        chk("uninh_one_edge", last_one - e0, 6);
        idle_wait("uninh_idle");

        // reset mid-flight with the line still high
        c0 = n_five; r0 = n_rej;
        coin5_raw = 1;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_outputs_a", int'({one, two, five, reject, busy}), 0);
        @(negedge clk);
        chk("rst_outputs_b", int'({one, two, five, reject, busy}), 0);
        reset = 0; e0 = cyc + 1;
        repeat (10) @(negedge clk);
        coin5_raw = 0;
        chk("rst_five_count", n_five - c0, 1);
        chk("rst_five_edge", last_five - e0, D + 2);
        chk("rst_no_reject", n_rej - r0, 0);
        idle_wait("rst_idle");

        // random traffic
        acc0 = n_one + n_two + n_five;
        for (int i = 0; i < 3; i++) hold[i] = 0;
        lv = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    lv[i]   = ($urandom_range(0, 2) == 0);
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            coin1_raw = lv[0];
            coin2_raw = lv[1];
            coin5_raw = lv[2];
            if ($urandom_range(0, 15) == 0) inhibit = ~inhibit;
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        reset = 0; inhibit = 0;
        coin1_raw = 0; coin2_raw = 0; coin5_raw = 0;
        idle_wait("random_idle");
        chk("random_accepts_seen",
            int'((n_one + n_two + n_five) > acc0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
